// File: rtl/ds1302_pkg.sv
// Shared definitions for the DS1302 serial slave: FSM encoding, register map,
// reset contents and BCD helper.
package ds1302_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_WDATA  = 3'd2,
    S_RDATA  = 3'd3,
    S_IGNORE = 3'd4
  } state_t;

  localparam int NUM_REGS = 8;

  localparam logic [2:0] IDX_SEC   = 3'd0;
  localparam logic [2:0] IDX_MIN   = 3'd1;
  localparam logic [2:0] IDX_HOUR  = 3'd2;
  localparam logic [2:0] IDX_DATE  = 3'd3;
  localparam logic [2:0] IDX_MONTH = 3'd4;
  localparam logic [2:0] IDX_DAY   = 3'd5;
  localparam logic [2:0] IDX_YEAR  = 3'd6;
  localparam logic [2:0] IDX_WP    = 3'd7;

  // Write-command addresses; the read command is the same value with bit0 set.
  localparam logic [7:0] ADDR_SEC   = 8'h80;
  localparam logic [7:0] ADDR_MIN   = 8'h82;
  localparam logic [7:0] ADDR_HOUR  = 8'h84;
  localparam logic [7:0] ADDR_DATE  = 8'h86;
  localparam logic [7:0] ADDR_MONTH = 8'h88;
  localparam logic [7:0] ADDR_DAY   = 8'h8A;
  localparam logic [7:0] ADDR_YEAR  = 8'h8C;
  localparam logic [7:0] ADDR_WP    = 8'h8E;
  localparam logic [7:0] ADDR_BURST = 8'hBE;

  localparam logic [7:0] RST_VALS [NUM_REGS] = '{
    8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h80
  };

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'h0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/ds1302_slave_if.sv
// Control/status bundle of the DS1302 slave: serial CE/SCLK from the master,
// the one-second tick, and the time/status outputs.
interface ds1302_slave_if;
  logic       ds1302_ce;
  logic       ds1302_sclk;
  logic       sec_tick;
  logic [7:0] time_second;
  logic [7:0] time_minute;
  logic [7:0] time_hour;
  logic       wp;
  logic       busy;

  modport slave (
    input  ds1302_ce, ds1302_sclk, sec_tick,
    output time_second, time_minute, time_hour, wp, busy
  );

  modport master (
    output ds1302_ce, ds1302_sclk, sec_tick,
    input  time_second, time_minute, time_hour, wp, busy
  );
endinterface

// File: rtl/ds1302_slv_sync.sv
// Synchronizes the asynchronous serial-bus pins into clk and flags SCLK edges
// seen on the synchronized level.
module ds1302_slv_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic sclk,
  input  logic io,
  output logic ce_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic io_s
);

  logic [SYNC_STAGES-1:0] ce_ff;
  logic [SYNC_STAGES-1:0] sclk_ff;
  logic [SYNC_STAGES-1:0] io_ff;
  logic                   sclk_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_ff   <= '0;
      sclk_ff <= '0;
      io_ff   <= '0;
      sclk_d  <= 1'b0;
    end else begin
      ce_ff[0]   <= ce;
      sclk_ff[0] <= sclk;
      io_ff[0]   <= io;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ce_ff[i]   <= ce_ff[i-1];
        sclk_ff[i] <= sclk_ff[i-1];
        io_ff[i]   <= io_ff[i-1];
      end
      sclk_d <= sclk_ff[SYNC_STAGES-1];
    end
  end

  assign ce_s      = ce_ff[SYNC_STAGES-1];
  assign io_s      = io_ff[SYNC_STAGES-1];
  assign sclk_rise =  sclk_ff[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_ff[SYNC_STAGES-1] &  sclk_d;

endmodule

// File: rtl/ds1302_slave.sv
// DS1302-compatible serial slave with clock/calendar registers and a seconds
// ticker. Define DS1302_SLV_BURST_EN to enable the 0xBE/0xBF burst commands.
//
// state    | meaning
// S_IDLE   | CE low, waiting for CE rise
// S_CMD    | shifting the 8-bit command byte
// S_WDATA  | shifting write data, commit on the last bit
// S_RDATA  | driving snapshot bits on SCLK falling edges
// S_IGNORE | transfer finished or rejected, wait for CE low
module ds1302_slave
  import ds1302_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  ds1302_slave_if.slave   bus,
  inout  wire             ds1302_io
);

`ifdef DS1302_SLV_BURST_EN
  localparam int DATA_BITS = 64;
`else
  localparam int DATA_BITS = 8;
`endif
  localparam int IDXW = $clog2(DATA_BITS);

  logic ce_s, sclk_rise, sclk_fall, io_s;

  ds1302_slv_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .ce        (bus.ds1302_ce),
    .sclk      (bus.ds1302_sclk),
    .io        (ds1302_io),
    .ce_s      (ce_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .io_s      (io_s)
  );

  state_t                 state_q, state_d;
  logic [6:0]             bit_cnt;
  logic [6:0]             cmd_sr;
  logic [7:0]             cmd_next;
  logic [DATA_BITS-2:0]   data_sr;
  logic [DATA_BITS-1:0]   wword;
  logic [DATA_BITS-1:0]   rd_buf;
  logic [DATA_BITS-1:0]   snap;
  logic [2:0]             addr_q;
  logic                   burst_q;
  logic                   io_oe, io_q;
  logic                   tick_pend;
  logic [7:0]             regs [NUM_REGS];

  logic       single_ok, burst_ok, cmd_done, commit, rd_done;
  logic [6:0] last_wbit, nbits_rd;

  // Shift registers hold the bits received so far; the incoming bit completes them.
  assign cmd_next = {io_s, cmd_sr};
  assign wword    = {io_s, data_sr};

  always_comb begin
    single_ok = cmd_next[7] & ~cmd_next[6] & (cmd_next[5:4] == 2'b00);
`ifdef DS1302_SLV_BURST_EN
    burst_ok  = cmd_next[7] & ~cmd_next[6] & (cmd_next[5:1] == ADDR_BURST[5:1]);
`else
    burst_ok  = 1'b0;
`endif
    last_wbit = burst_q ? 7'd63 : 7'd7;
    nbits_rd  = burst_q ? 7'd64 : 7'd8;
    cmd_done  = (state_q == S_CMD)   && sclk_rise && (bit_cnt == 7'd7);
    commit    = ce_s && (state_q == S_WDATA) && sclk_rise && (bit_cnt == last_wbit);
    rd_done   = (state_q == S_RDATA) && sclk_fall && (bit_cnt == nbits_rd);
  end

  always_comb begin
    snap      = '0;
    snap[7:0] = regs[cmd_next[3:1]];
`ifdef DS1302_SLV_BURST_EN
    if (burst_ok)
      for (int k = 0; k < NUM_REGS; k++) snap[8*k +: 8] = regs[k];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!ce_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_CMD;
        S_CMD:    if (cmd_done) begin
                    if (!(single_ok || burst_ok)) state_d = S_IGNORE;
                    else if (cmd_next[0])         state_d = S_RDATA;
                    else                          state_d = S_WDATA;
                  end
        S_WDATA:  if (commit)  state_d = S_IGNORE;
        S_RDATA:  if (rd_done) state_d = S_IGNORE;
        S_IGNORE: state_d = S_IGNORE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      cmd_sr  <= '0;
      data_sr <= '0;
      rd_buf  <= '0;
      addr_q  <= '0;
      burst_q <= 1'b0;
      io_oe   <= 1'b0;
      io_q    <= 1'b0;
    end else begin
      case (state_q)
        S_CMD: if (sclk_rise) begin
          cmd_sr <= cmd_next[7:1];
          if (bit_cnt == 7'd7) begin
            bit_cnt <= '0;
            addr_q  <= cmd_next[3:1];
            burst_q <= burst_ok;
            rd_buf  <= snap;
          end else begin
            bit_cnt <= bit_cnt + 7'd1;
          end
        end
        S_WDATA: if (sclk_rise) begin
          data_sr <= wword[DATA_BITS-1:1];
          bit_cnt <= bit_cnt + 7'd1;
        end
        S_RDATA: if (sclk_fall) begin
          if (bit_cnt == nbits_rd) begin
            io_oe <= 1'b0;
          end else begin
            io_oe   <= 1'b1;
            io_q    <= rd_buf[bit_cnt[IDXW-1:0]];
            bit_cnt <= bit_cnt + 7'd1;
          end
        end
        default: bit_cnt <= '0;
      endcase
      if (!ce_s || state_q != S_RDATA) io_oe <= 1'b0;
    end
  end

  // A tick that lands on a commit is deferred one clk so it acts on the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= RST_VALS[k];
      tick_pend <= 1'b0;
    end else if (commit) begin
`ifdef DS1302_SLV_BURST_EN
      if (burst_q) begin
        for (int k = 0; k < NUM_REGS - 1; k++)
          if (!regs[IDX_WP][7]) regs[k] <= wword[8*k +: 8];
        regs[IDX_WP] <= {wword[DATA_BITS-1], 7'b0};
      end else
`endif
      if (addr_q == IDX_WP)      regs[IDX_WP] <= {wword[DATA_BITS-1], 7'b0};
      else if (!regs[IDX_WP][7]) regs[addr_q] <= wword[DATA_BITS-1 -: 8];
      tick_pend <= tick_pend | bus.sec_tick;
    end else begin
      tick_pend <= 1'b0;
      if ((bus.sec_tick || tick_pend) && !regs[IDX_SEC][7]) begin
        if (regs[IDX_SEC][6:0] == 7'h59) begin
          regs[IDX_SEC] <= 8'h00;
          if (regs[IDX_MIN][6:0] == 7'h59) begin
            regs[IDX_MIN] <= 8'h00;
            if (regs[IDX_HOUR][5:0] == 6'h23) regs[IDX_HOUR] <= {regs[IDX_HOUR][7:6], 6'h00};
            else                              regs[IDX_HOUR] <= bcd_inc(regs[IDX_HOUR]);
          end else begin
            regs[IDX_MIN] <= bcd_inc(regs[IDX_MIN]);
          end
        end else begin
          regs[IDX_SEC] <= bcd_inc(regs[IDX_SEC]);
        end
      end
    end
  end

  assign ds1302_io       = io_oe ? io_q : 1'bz;
  assign bus.time_second = regs[IDX_SEC];
  assign bus.time_minute = regs[IDX_MIN];
  assign bus.time_hour   = regs[IDX_HOUR];
  assign bus.wp          = regs[IDX_WP][7];
  assign bus.busy        = ce_s;

endmodule

// File: tb/tb_ds1302_slave.sv
// Directed bench for ds1302_slave: bit-banged 3-wire master, pulled-up io line,
// hand-computed expectations.
module tb_ds1302_slave;
  import ds1302_pkg::*;

  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tb_oe = 1'b0;
  logic tb_d = 1'b0;
  logic [7:0] rd_val;
  logic [7:0] snap_min, snap_sec;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ds1302_slave_if bus();
  wire ds1302_io;
  assign ds1302_io = tb_oe ? tb_d : 1'bz;
  pullup (ds1302_io);

  ds1302_slave #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ds1302_io (ds1302_io)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ce_on();
    bus.ds1302_ce = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic ce_off();
    wait_clk(HALF);
    bus.ds1302_ce = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input bit tick_last);
    for (int i = 0; i < n; i++) begin
      tb_oe = 1'b1;
      tb_d  = b[i];
      wait_clk(HALF);
      bus.ds1302_sclk = 1'b1;
      if (tick_last && i == n - 1) begin
        wait_clk(2);
        bus.sec_tick = 1'b1;
        wait_clk(1);
        bus.sec_tick = 1'b0;
        snap_min = bus.time_minute;
        snap_sec = bus.time_second;
        wait_clk(HALF - 3);
      end else begin
        wait_clk(HALF);
      end
      bus.ds1302_sclk = 1'b0;
    end
    tb_oe = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    tb_oe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_clk(HALF);
      b[i] = ds1302_io;
      bus.ds1302_sclk = 1'b1;
      wait_clk(HALF);
      bus.ds1302_sclk = 1'b0;
    end
  endtask

  task automatic write_reg(input logic [7:0] cmd, input logic [7:0] data);
    ce_on();
    send_bits(cmd, 8, 1'b0);
    send_bits(data, 8, 1'b0);
    ce_off();
  endtask

  task automatic read_reg(input logic [7:0] cmd, output logic [7:0] val);
    ce_on();
    send_bits(cmd, 8, 1'b0);
    recv_byte(val);
    wait_clk(HALF);
    check("io_released_after_read", {7'b0, ds1302_io}, 8'h01);
    ce_off();
  endtask

  task automatic tick();
    bus.sec_tick = 1'b1;
    wait_clk(1);
    bus.sec_tick = 1'b0;
    wait_clk(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ds1302_ce   = 1'b0;
    bus.ds1302_sclk = 1'b0;
    bus.sec_tick    = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);

    check("rst_second", bus.time_second, 8'h00);
    check("rst_minute", bus.time_minute, 8'h00);
    check("rst_hour",   bus.time_hour,   8'h00);
    check("rst_wp",     {7'b0, bus.wp},   8'h01);
    check("rst_busy",   {7'b0, bus.busy}, 8'h00);
    check("rst_io_z",   {7'b0, ds1302_io}, 8'h01);

    read_reg(ADDR_SEC | 8'h01, rd_val);  check("rd_sec_rst",  rd_val, 8'h00);
    read_reg(ADDR_WP | 8'h01, rd_val);   check("rd_wp_rst",   rd_val, 8'h80);
    read_reg(ADDR_DATE | 8'h01, rd_val); check("rd_date_rst", rd_val, 8'h01);

    bus.ds1302_ce = 1'b1;
    wait_clk(HALF);
    check("busy_high", {7'b0, bus.busy}, 8'h01);
    bus.ds1302_ce = 1'b0;
    wait_clk(HALF);
    check("busy_low", {7'b0, bus.busy}, 8'h00);

    // Write protection
    write_reg(ADDR_SEC, 8'h45);
    check("wp_blocks_sec", bus.time_second, 8'h00);
    write_reg(ADDR_WP, 8'h00);
    check("wp_cleared", {7'b0, bus.wp}, 8'h00);
    write_reg(ADDR_SEC, 8'h45);
    check("sec_written", bus.time_second, 8'h45);
    read_reg(ADDR_SEC | 8'h01, rd_val);
    check("rd_sec_45", rd_val, 8'h45);

    // Seconds ticker
    tick();
    check("tick_46", bus.time_second, 8'h46);
    write_reg(ADDR_SEC, 8'h09);
    tick();
    check("tick_bcd_carry", bus.time_second, 8'h10);
    write_reg(ADDR_SEC, 8'h59);
    write_reg(ADDR_MIN, 8'h59);
    write_reg(ADDR_HOUR, 8'h23);
    tick();
    check("wrap_sec",  bus.time_second, 8'h00);
    check("wrap_min",  bus.time_minute, 8'h00);
    check("wrap_hour", bus.time_hour,   8'h00);
    write_reg(ADDR_SEC, 8'h80);
    tick();
    check("ch_halts", bus.time_second, 8'h80);

    // Aborted write and aborted read
    ce_on();
    send_bits(ADDR_MIN, 8, 1'b0);
    send_bits(8'h12, 5, 1'b0);
    bus.ds1302_ce = 1'b0;
    wait_clk(HALF);
    check("abort_min_unchanged", bus.time_minute, 8'h00);
    check("abort_wr_io_z", {7'b0, ds1302_io}, 8'h01);
    ce_on();
    send_bits(ADDR_SEC | 8'h01, 8, 1'b0);
    wait_clk(HALF);
    check("rd_bit0_driven", {7'b0, ds1302_io}, 8'h00);
    bus.ds1302_ce = 1'b0;
    wait_clk(HALF);
    check("abort_rd_io_z", {7'b0, ds1302_io}, 8'h01);
    write_reg(ADDR_MIN, 8'h12);
    check("after_abort_min", bus.time_minute, 8'h12);

    // Tick coinciding with a commit
    write_reg(ADDR_SEC, 8'h59);
    ce_on();
    send_bits(ADDR_MIN, 8, 1'b0);
    send_bits(8'h30, 8, 1'b1);
    ce_off();
    check("coinc_min_commit", snap_min, 8'h30);
    check("coinc_sec_held",   snap_sec, 8'h59);
    check("coinc_min_final",  bus.time_minute, 8'h31);
    check("coinc_sec_final",  bus.time_second, 8'h00);

    // WP register stores only bit7
    write_reg(ADDR_WP, 8'hFF);
    check("wp_set", {7'b0, bus.wp}, 8'h01);
    read_reg(ADDR_WP | 8'h01, rd_val);
    check("rd_wp_bit7_only", rd_val, 8'h80);
    write_reg(ADDR_MIN, 8'h55);
    check("wp_blocks_min", bus.time_minute, 8'h31);
    write_reg(ADDR_WP, 8'h00);

    // Rejected commands leave io undriven
    ce_on();
    send_bits(8'hC1, 8, 1'b0);
    recv_byte(rd_val);
    ce_off();
    check("ram_cmd_ignored", rd_val, 8'hFF);
    ce_on();
    send_bits(8'h03, 8, 1'b0);
    recv_byte(rd_val);
    ce_off();
    check("bad_bit7_ignored", rd_val, 8'hFF);

`ifdef DS1302_SLV_BURST_EN
    begin
      logic [7:0] bvals [8];
      bvals = '{8'h12, 8'h34, 8'h15, 8'h27, 8'h11, 8'h03, 8'h24, 8'h00};
      ce_on();
      send_bits(ADDR_BURST, 8, 1'b0);
      for (int k = 0; k < 8; k++) send_bits(bvals[k], 8, 1'b0);
      ce_off();
      check("burst_wr_sec",  bus.time_second, 8'h12);
      check("burst_wr_min",  bus.time_minute, 8'h34);
      check("burst_wr_hour", bus.time_hour,   8'h15);
      ce_on();
      send_bits(ADDR_BURST | 8'h01, 8, 1'b0);
      for (int k = 0; k < 8; k++) begin
        recv_byte(rd_val);
        check("burst_rd_byte", rd_val, bvals[k]);
      end
      wait_clk(HALF);
      check("burst_io_released", {7'b0, ds1302_io}, 8'h01);
      ce_off();
    end
`else
    ce_on();
    send_bits(ADDR_BURST | 8'h01, 8, 1'b0);
    recv_byte(rd_val);
    check("burst_rd_off_b0", rd_val, 8'hFF);
    recv_byte(rd_val);
    check("burst_rd_off_b1", rd_val, 8'hFF);
    ce_off();
    ce_on();
    send_bits(ADDR_BURST, 8, 1'b0);
    send_bits(8'h22, 8, 1'b0);
    ce_off();
    check("burst_wr_off_sec", bus.time_second, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
